// File: rtl/data_mem_ctrl.sv
// Load/store front end for the data memory: buffers stores and drains them in idle cycles.
// Loads forward from the youngest matching buffered store and return one cycle after acceptance.
module data_mem_ctrl #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        wb_empty,
    output logic        wb_full,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_Write_data,
    output logic [1:0]  mem_MemWrite,
    output logic [1:0]  mem_MemRead,
    input  logic [31:0] mem_Read_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Handshake: a request transfers on a posedge where req_valid && req_ready.
    logic [31:0]      buf_addr [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic             buf_byte [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             fwd_hit;
    logic             fwd_byte;
    logic [31:0]      fwd_data;
    logic [PTR_W-1:0] idx;
    logic             hazard;
    logic             load_acc;
    logic             store_acc;
    logic             drain;
    logic [7:0]       load_byte;
    logic [31:0]      load_result;

    // Walk oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_byte = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) &&
                (buf_addr[idx][ADDR_BITS-1:0] == req_addr[ADDR_BITS-1:0])) begin
                fwd_hit  = 1'b1;
                fwd_byte = buf_byte[idx];
                fwd_data = buf_data[idx];
            end
        end
    end

    assign hazard    = fwd_hit && fwd_byte && !req_size;
    assign wb_full   = (count == FULL_CNT);
    assign wb_empty  = (count == '0);
    assign req_ready = req_we ? !wb_full : !hazard;
    assign load_acc  = req_valid && req_ready && !req_we;
    assign store_acc = req_valid && req_ready && req_we;
    assign drain     = !load_acc && !wb_empty;

    assign load_byte   = fwd_hit ? fwd_data[7:0] : mem_Read_data[7:0];
    assign load_result = req_size ? {{24{req_signed & load_byte[7]}}, load_byte}
                                  : (fwd_hit ? fwd_data : mem_Read_data);

    // Gated by rst_n so an asserted reset silences the memory without waiting for a clock.
    always_comb begin
        mem_Address    = '0;
        mem_Write_data = '0;
        mem_MemWrite   = 2'b00;
        mem_MemRead    = 2'b00;
        if (rst_n) begin
            if (load_acc) begin
                mem_Address = req_addr;
                mem_MemRead = req_size ? 2'b10 : 2'b01;
            end else if (drain) begin
                mem_Address    = buf_addr[head];
                mem_Write_data = buf_data[head];
                mem_MemWrite   = buf_byte[head] ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= load_acc;
            if (load_acc) rsp_data <= load_result;
            if (store_acc) tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            case ({store_acc, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            buf_addr[tail] <= req_addr;
            buf_data[tail] <= req_wdata;
            buf_byte[tail] <= req_size;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus random traffic against a program-order memory model.
module tb_data_mem_ctrl;
    localparam int DEPTH     = 4;
    localparam int ADDR_BITS = 8;
    localparam int W         = 65;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_size = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        wb_empty;
    logic        wb_full;
    logic [31:0] mem_Address;
    logic [31:0] mem_Write_data;
    logic [1:0]  mem_MemWrite;
    logic [1:0]  mem_MemRead;
    logic [31:0] mem_Read_data;

    data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wb_empty(wb_empty), .wb_full(wb_full), .mem_Address(mem_Address),
        .mem_Write_data(mem_Write_data), .mem_MemWrite(mem_MemWrite),
        .mem_MemRead(mem_MemRead), .mem_Read_data(mem_Read_data)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Environment memory and program-order reference
    logic [31:0]  mem [256];
    logic [31:0]  arch [256];
    logic [W-1:0] exp_q[$];   // accepted stores not yet committed: {byte, addr, data}
    logic         pend_rsp = 1'b0;
    logic [31:0]  pend_data = '0;
    logic         last_acc = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;

    assign mem_Read_data = mem[mem_Address[ADDR_BITS-1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: every memory write must be the oldest outstanding store.
    always @(negedge clk) begin
        if (mem_MemWrite != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("drain_unexpected", 32'(mem_MemWrite), 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("drain_addr", mem_Address, e[63:32]);
                check("drain_data", mem_Write_data, e[31:0]);
                check("drain_kind", 32'(mem_MemWrite), e[64] ? 32'd2 : 32'd1);
            end
            if (mem_MemWrite == 2'b01) mem[mem_Address[ADDR_BITS-1:0]] = mem_Write_data;
            else if (mem_MemWrite == 2'b10) mem[mem_Address[ADDR_BITS-1:0]][7:0] = mem_Write_data[7:0];
        end
    end

    // Driver: one request per cycle, checked against the reference before the negedge.
    task automatic step(input logic v, input logic we, input logic sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
        logic        haz, exp_rdy, acc;
        logic [31:0] ea, ewd;
        logic [1:0]  emw, emr;
        logic [7:0]  b;
        @(posedge clk);
        #1;
        req_valid = v; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        #2;
        check("rsp_valid", 32'(rsp_valid), 32'(pend_rsp));
        if (pend_rsp) check("rsp_data", rsp_data, pend_data);
        haz = 1'b0;
        foreach (exp_q[i])
            if (exp_q[i][32+ADDR_BITS-1:32] == a[ADDR_BITS-1:0]) haz = exp_q[i][64] && !sz;
        exp_rdy = we ? (exp_q.size() < DEPTH) : !haz;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("wb_empty", 32'(wb_empty), 32'(exp_q.size() == 0));
        check("wb_full", 32'(wb_full), 32'(exp_q.size() == DEPTH));
        acc = v && exp_rdy;
        ea = '0; ewd = '0; emw = 2'b00; emr = 2'b00;
        if (acc && !we) begin
            ea  = a;
            emr = sz ? 2'b10 : 2'b01;
        end else if (exp_q.size() > 0) begin
            ea  = exp_q[0][63:32];
            ewd = exp_q[0][31:0];
            emw = exp_q[0][64] ? 2'b10 : 2'b01;
        end
        check("mem_Address", mem_Address, ea);
        check("mem_MemWrite", 32'(mem_MemWrite), 32'(emw));
        check("mem_MemRead", 32'(mem_MemRead), 32'(emr));
        if (!(acc && !we)) check("mem_Write_data", mem_Write_data, ewd);
        last_acc = acc;
        pend_rsp = acc && !we;
        if (acc && !we) begin
            b = arch[a[ADDR_BITS-1:0]][7:0];
            if (sz) pend_data = sg ? {{24{b[7]}}, b} : {24'd0, b};
            else pend_data = arch[a[ADDR_BITS-1:0]];
        end
        if (acc && we) begin
            exp_q.push_back({sz, a, d});
            if (sz) arch[a[ADDR_BITS-1:0]][7:0] = d[7:0];
            else arch[a[ADDR_BITS-1:0]] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        bit done;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = $urandom;
            arch[i] = mem[i];
        end

        // Power-on reset
        repeat (2) @(posedge clk);
        #3;
        check("rst_MemWrite", 32'(mem_MemWrite), 32'd0);
        check("rst_MemRead", 32'(mem_MemRead), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_wb_empty", 32'(wb_empty), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Word store, drain, then word load from memory
        step(1, 1, 0, 0, 32'd5, 32'h12345678);
        idle(2);
        step(1, 0, 0, 0, 32'd5, 32'd0);
        idle(1);
        check("word_load", rsp_data, 32'h12345678);

        // Forwarding from the buffer
        step(1, 1, 0, 0, 32'd9, 32'hAABBCCDD);
        step(1, 0, 0, 0, 32'd9, 32'd0);
        check("fwd_not_drained", 32'(wb_empty), 32'd0);
        step(1, 0, 1, 1, 32'd9, 32'd0);
        check("fwd_word", rsp_data, 32'hAABBCCDD);
        step(1, 0, 1, 0, 32'd9, 32'd0);
        check("fwd_byte_signed", rsp_data, 32'hFFFFFFDD);
        idle(1);
        check("fwd_byte_unsigned", rsp_data, 32'h000000DD);
        idle(2);

        // Byte store, drain, byte loads from memory
        step(1, 1, 1, 0, 32'd3, 32'h00000080);
        idle(2);
        step(1, 0, 1, 1, 32'd3, 32'd0);
        check("byte_MemRead", 32'(mem_MemRead), 32'd2);
        step(1, 0, 1, 0, 32'd3, 32'd0);
        check("byte_signed", rsp_data, 32'hFFFFFF80);
        idle(1);
        check("byte_unsigned", rsp_data, 32'h00000080);

        // Word load behind a buffered byte store stalls until it drains
        step(1, 1, 1, 0, 32'd7, 32'h00000011);
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            step(1, 0, 0, 0, 32'd7, 32'd0);
            done = last_acc;
        end
        check("hazard_accept", 32'(done), 32'd1);
        idle(1);
        check("hazard_low_byte", 32'(rsp_data[7:0]), 32'h11);

        // Back-to-back loads starve the drain
        step(1, 1, 0, 0, 32'd50, 32'hCAFEF00D);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 32'd51 + k, 32'd0);
        check("starved_pending", 32'(wb_empty), 32'd0);
        idle(2);

        // Reset asserted while a drain is being presented
        step(1, 1, 0, 0, 32'd40, 32'h5A5A5A5A);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("mid_drain_MemWrite", 32'(mem_MemWrite), 32'd0);
        exp_q.delete();
        pend_rsp = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 256; i++) arch[i] = mem[i];
        @(posedge clk);
        #3;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_rsp_data", rsp_data, 32'd0);
        check("post_rst_wb_empty", 32'(wb_empty), 32'd1);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Random traffic over a small address window to force collisions
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), 32'($urandom_range(0, 15)), $urandom);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
